// File: rtl/fadd36_pkg.sv
// Shared constants, packed result layout and helpers for the FADD_36
// normalize/round back end.
package fadd36_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 27;
    localparam int SIG_W   = 28;
    localparam int SUM_W   = 37;
    localparam int LZD_W   = 6;
    localparam int RES_W   = 36;
    localparam int EEXP_W  = 10;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Field positions inside the raw 37-bit sum
    localparam int SUM_CARRY_BIT = 36;
    localparam int SUM_SIG_HI    = 35;
    localparam int SUM_SIG_LO    = 8;
    localparam int SUM_GUARD_BIT = 7;

    localparam logic signed [EEXP_W-1:0] EXP_MAX_E = EEXP_W'(EXP_MAX);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fadd36_t;

    localparam fadd36_t ZERO = '0;

    function automatic fadd36_t inf_val(input logic s);
        fadd36_t r;
        r.sign = s;
        r.exp  = '1;
        r.frac = '0;
        return r;
    endfunction

    function automatic fadd36_t signed_zero(input logic s);
        fadd36_t r;
        r      = ZERO;
        r.sign = s;
        return r;
    endfunction

endpackage

// File: rtl/fadd36_nshift.sv
// Normalizing shifter: right by one on carry-out, otherwise left by lzd-1,
// producing significand, guard and sticky of the normalized sum.
module fadd36_nshift
    import fadd36_pkg::*;
(
    input  logic [SUM_W-1:0] i_mant,
    input  logic [LZD_W-1:0] i_lzd,
    output logic [SIG_W-1:0] o_sig,
    output logic             o_guard,
    output logic             o_sticky
);

    logic [SUM_W-2:0] norm;
    logic             shift_out;

    always_comb begin
        norm      = i_mant[SUM_W-2:0];
        shift_out = 1'b0;
        if (i_lzd == '0) begin
            norm      = i_mant[SUM_CARRY_BIT:1];
            shift_out = i_mant[0];
        end else if (i_lzd != LZD_W'(1)) begin
            norm = i_mant[SUM_W-2:0] << (i_lzd - LZD_W'(1));
        end
    end

    assign o_sig    = norm[SUM_SIG_HI:SUM_SIG_LO];
    assign o_guard  = norm[SUM_GUARD_BIT];
    assign o_sticky = (|norm[SUM_GUARD_BIT-1:0]) | shift_out;

endmodule

// File: rtl/fadd36_norm_round.sv
// Two-stage valid/ready back end of the 36-bit adder: stage 1 normalizes,
// stage 2 rounds to nearest-even, applies exceptions and packs the result.
module fadd36_norm_round
    import fadd36_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [SUM_W-1:0] i_mant,
    input  logic [LZD_W-1:0] i_lzd,
    input  logic             i_special,
    input  logic [RES_W-1:0] i_special_val,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [RES_W-1:0] o_result,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_inexact
);

    logic s1_adv, s2_adv, accept;

    logic [SIG_W-1:0]  ns_sig;
    logic              ns_guard, ns_sticky;
    logic [EEXP_W-1:0] e1_d;

    logic                     s1_valid_q, s1_sign_q, s1_guard_q, s1_sticky_q;
    logic                     s1_zero_q, s1_special_q;
    logic signed [EEXP_W-1:0] s1_exp_q;
    logic [SIG_W-1:0]         s1_sig_q;
    logic [RES_W-1:0]         s1_special_val_q;

    logic                     s2_valid_q, s2_ovf_q, s2_unf_q, s2_inx_q;
    fadd36_t                  s2_result_q;

    logic                     round_up;
    logic [FRAC_W:0]          frac_rnd;
    logic signed [EEXP_W-1:0] e_fin;
    fadd36_t                  res_d;
    logic                     ovf_d, unf_d, inx_d;

    assign s2_adv  = ~s2_valid_q | i_ready;
    assign s1_adv  = ~s1_valid_q | s2_adv;
    assign o_ready = s1_adv;
    assign accept  = i_valid & s1_adv;

    fadd36_nshift u_nshift (
        .i_mant   (i_mant),
        .i_lzd    (i_lzd),
        .o_sig    (ns_sig),
        .o_guard  (ns_guard),
        .o_sticky (ns_sticky)
    );

    // Every lzd case collapses to exp + 1 - lzd
    assign e1_d = {2'b00, i_exp} + EEXP_W'(1) - {{(EEXP_W-LZD_W){1'b0}}, i_lzd};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q       <= 1'b0;
            s1_sign_q        <= 1'b0;
            s1_exp_q         <= '0;
            s1_sig_q         <= '0;
            s1_guard_q       <= 1'b0;
            s1_sticky_q      <= 1'b0;
            s1_zero_q        <= 1'b0;
            s1_special_q     <= 1'b0;
            s1_special_val_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= i_valid;
            end
            if (accept) begin
                s1_sign_q        <= i_sign;
                s1_exp_q         <= $signed(e1_d);
                s1_sig_q         <= ns_sig;
                s1_guard_q       <= ns_guard;
                s1_sticky_q      <= ns_sticky;
                s1_zero_q        <= ~|i_mant;
                s1_special_q     <= i_special;
                s1_special_val_q <= i_special_val;
            end
        end
    end

    // Hidden bit is 1 for any non-zero sum, so a carry out of the 27-bit
    // fraction is the same as a carry out of the 28-bit significand.
    always_comb begin
        round_up = s1_guard_q & (s1_sticky_q | s1_sig_q[0]);
        frac_rnd = {1'b0, s1_sig_q[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, round_up};
        e_fin    = s1_exp_q + $signed({{(EEXP_W-1){1'b0}}, frac_rnd[FRAC_W]});
        res_d.sign = s1_sign_q;
        res_d.exp  = e_fin[EXP_W-1:0];
        res_d.frac = frac_rnd[FRAC_W-1:0];
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = s1_guard_q | s1_sticky_q;
        if (s1_special_q) begin
            res_d = fadd36_t'(s1_special_val_q);
            inx_d = 1'b0;
        end else if (s1_zero_q || !s1_sig_q[SIG_W-1]) begin
            res_d = ZERO;
            inx_d = 1'b0;
        end else if (e_fin >= EXP_MAX_E) begin
            res_d = inf_val(s1_sign_q);
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            res_d = signed_zero(s1_sign_q);
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= ZERO;
            s2_ovf_q    <= 1'b0;
            s2_unf_q    <= 1'b0;
            s2_inx_q    <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_valid_q && s2_adv) begin
                s2_result_q <= res_d;
                s2_ovf_q    <= ovf_d;
                s2_unf_q    <= unf_d;
                s2_inx_q    <= inx_d;
            end
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_result    = s2_result_q;
    assign o_overflow  = s2_ovf_q;
    assign o_underflow = s2_unf_q;
    assign o_inexact   = s2_inx_q;

endmodule

// File: tb/tb_fadd36_norm_round.sv
// Scoreboard bench for fadd36_norm_round: directed vectors, latency,
// backpressure hold and mid-flight reset.
module tb_fadd36_norm_round;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [36:0] i_mant = '0;
    logic [5:0]  i_lzd = '0;
    logic        i_special = 1'b0;
    logic [35:0] i_special_val = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [35:0] o_result;
    logic        o_overflow, o_underflow, o_inexact;

    fadd36_norm_round dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sign        (i_sign),
        .i_exp         (i_exp),
        .i_mant        (i_mant),
        .i_lzd         (i_lzd),
        .i_special     (i_special),
        .i_special_val (i_special_val),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow),
        .o_inexact     (o_inexact)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        sg;
        logic [7:0]  ex;
        logic [36:0] m;
        logic [5:0]  lz;
        logic        sp;
        logic [35:0] sv;
        logic [35:0] res;
        logic [2:0]  fl;   // {overflow, underflow, inexact}
    } vec_t;

    typedef struct packed {
        logic [35:0] res;
        logic [2:0]  fl;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   n_out    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic vec_t mk(input logic sg, input logic [7:0] ex, input logic [36:0] m,
                                input logic [5:0] lz, input logic sp, input logic [35:0] sv,
                                input logic [35:0] res, input logic [2:0] fl);
        vec_t v;
        v.sg = sg; v.ex = ex; v.m = m; v.lz = lz; v.sp = sp; v.sv = sv; v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        i_valid       = 1'b1;
        i_sign        = v.sg;
        i_exp         = v.ex;
        i_mant        = v.m;
        i_lzd         = v.lz;
        i_special     = v.sp;
        i_special_val = v.sv;
        #1;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk);
            #2;
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", 64'(o_ready), 64'd1);
        e.res = v.res;
        e.fl  = v.fl;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks that
    // stalled outputs stay stable.
    bit          stall_prev = 1'b0;
    logic [35:0] held_res;
    logic [2:0]  held_fl;
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            stall_prev = 1'b0;
        end else if (o_valid) begin
            if (stall_prev) begin
                check_eq("hold_result", 64'(o_result), 64'(held_res));
                check_eq("hold_flags", 64'({o_overflow, o_underflow, o_inexact}), 64'(held_fl));
            end
            if (i_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    $display("out %0d: result=0x%09h ovf=%0b unf=%0b inx=%0b (want 0x%09h %03b)",
                             n_out, o_result, o_overflow, o_underflow, o_inexact, e.res, e.fl);
                    check_eq("result", 64'(o_result), 64'(e.res));
                    check_eq("flags", 64'({o_overflow, o_underflow, o_inexact}), 64'(e.fl));
                end
            end
            stall_prev = ~i_ready;
            held_res   = o_result;
            held_fl    = {o_overflow, o_underflow, o_inexact};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int n;
        vecs.push_back(mk(0, 8'd127, 37'h1 << 36, 6'd0, 0, '0, 36'h400000000, 3'b000)); // 1.0+1.0
        vecs.push_back(mk(0, 8'd127, (37'h1 << 35) | (37'h1 << 7), 6'd1, 0, '0, 36'h3F8000000, 3'b001));
        vecs.push_back(mk(0, 8'd127, (37'h1 << 35) | (37'h1 << 8) | (37'h1 << 7), 6'd1, 0, '0, 36'h3F8000002, 3'b001));
        vecs.push_back(mk(0, 8'd127, 37'h1 << 8, 6'd28, 0, '0, 36'h320000000, 3'b000));
        vecs.push_back(mk(0, 8'd20, 37'h1 << 8, 6'd28, 0, '0, 36'h000000000, 3'b011));
        vecs.push_back(mk(1, 8'd254, 37'h1 << 36, 6'd0, 0, '0, 36'hFF8000000, 3'b101));
        vecs.push_back(mk(0, 8'd100, 37'h0, 6'd36, 0, '0, 36'h000000000, 3'b000));
        vecs.push_back(mk(0, 8'd254, 37'h1 << 36, 6'd0, 1, 36'h7FC000000, 36'h7FC000000, 3'b000));
        vecs.push_back(mk(0, 8'd127, 37'h0FFFFFFF80, 6'd1, 0, '0, 36'h400000000, 3'b001)); // round carry
        vecs.push_back(mk(0, 8'd127, (37'h1 << 36) | 37'h1, 6'd0, 0, '0, 36'h400000000, 3'b001)); // shifted-out sticky
        vecs.push_back(mk(1, 8'd127, 37'h1 << 35, 6'd1, 0, '0, 36'hBF8000000, 3'b000));
        vecs.push_back(mk(0, 8'd127, 37'h1, 6'd36, 0, '0, 36'h2E0000000, 3'b000));
        vecs.push_back(mk(0, 8'd1, 37'h1 << 34, 6'd2, 0, '0, 36'h000000000, 3'b011));     // e == 0
        vecs.push_back(mk(0, 8'd2, 37'h1 << 34, 6'd2, 0, '0, 36'h008000000, 3'b000));     // e == 1
        vecs.push_back(mk(0, 8'd254, 37'h1 << 35, 6'd1, 0, '0, 36'h7F0000000, 3'b000));   // e == 254

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_result", 64'(o_result), 64'd0);
        check_eq("rst_flags", 64'({o_overflow, o_underflow, o_inexact}), 64'd0);
        #2;
        i_rst_n = 1'b1;
        #1;
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;

        // Latency of a single beat
        send(vecs[0]);
        check_eq("lat_edge1_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check_eq("lat_edge2_valid", 64'(o_valid), 64'd1);
        repeat (3) @(posedge i_clk);
        #1;

        // Back-to-back stream of every vector
        foreach (vecs[i]) send(vecs[i]);
        repeat (4) @(posedge i_clk);
        #1;

        // Backpressure: i_ready low for three cycles mid-stream
        fork
            begin
                for (int i = 1; i <= 5; i++) send(vecs[i]);
            end
            begin
                repeat (2) @(posedge i_clk);
                #1;
                i_ready = 1'b0;
                @(posedge i_clk);
                #1;
                check_eq("bp_ready_low", 64'(o_ready), 64'd0);
                repeat (2) @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge i_clk);
            n++;
        end
        check_eq("bp_drained", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk);
        #1;

        // Reset with two beats in flight
        send(vecs[6]);
        send(vecs[7]);
        check_eq("pre_rst_valid", 64'(o_valid), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(o_valid), 64'd0);
        check_eq("async_rst_result", 64'(o_result), 64'd0);
        exp_q.delete();
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", 64'(o_ready), 64'd1);
        check_eq("post_rst_valid", 64'(o_valid), 64'd0);
        repeat (5) @(posedge i_clk);
        #1;
        check_eq("flushed_valid", 64'(o_valid), 64'd0);

        // One more beat after reset must come through normally
        send(vecs[5]);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge i_clk);
            n++;
        end
        check_eq("final_drain", 64'(exp_q.size()), 64'd0);
        check_eq("out_count", 64'(n_out), 64'(1 + vecs.size() + 5 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
